align_shift_iter: RTL and testbench

//  Iterative right-shift aligner: the right-going, multi-cycle counterpart of the left normalizer that follows the LZD.

---
 rtl/shift_pkg.sv | 15 +
 rtl/align_stage.sv | 31 +++
 rtl/align_shift_iter.sv | 128 ++++++++++++
 tb/tb_align_shift_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the iterative right-shift aligner.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

    // Shift distance of stage i: the largest binary stage (WIDTH/2) runs first.
    function automatic int unsigned stage_amt(input int unsigned i, input int unsigned width);
        return width >> (i + 1);
    endfunction

endpackage

// File: rtl/align_stage.sv
// One binary right-shift stage, selected by stage index; reports the OR of the bits it drops.
module align_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SW-1:0]    stage_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o,
    output logic             sticky_o
);

    logic [WIDTH-1:0] ones;
    int unsigned      k;

    always_comb begin
        ones     = '1;
        k        = stage_amt(32'(stage_i), WIDTH);
        data_o   = data_i;
        sticky_o = 1'b0;
        if (en_i) begin
            // Vacated MSBs take the fill bit; dropped LSBs feed sticky.
            data_o   = (data_i >> k) | (fill_i ? ~(ones >> k) : '0);
            sticky_o = |(data_i & ~(ones << k));
        end
    end

endmodule

// File: rtl/align_shift_iter.sv
// Iterative right-shift aligner: one binary stage per cycle, largest first, with sticky
// accumulation and valid/ready handshakes on both sides.
module align_shift_iter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [SW-1:0]    Shift,
    input  logic             Arith,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Z,
    output logic             Sticky,
    output align_state_t     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and data stable until that edge.

    localparam logic [SW-1:0] LAST_CNT = SW'(SW);

    align_state_t     state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sticky_q, sticky_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic             fill_q, fill_d;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             stage_en;
    logic [WIDTH-1:0] stage_data;
    logic             stage_sticky;

    // Stage i consumes shift bit SW-1-i; the extra count value SW is a settle cycle.
    always_comb begin
        stage_en = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (cnt_q == SW'(i)) begin
                stage_en = shift_q[SW-1-i];
            end
        end
    end

    align_stage #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_stage (
        .data_i   (data_q),
        .stage_i  (cnt_q),
        .en_i     (stage_en),
        .fill_i   (fill_q),
        .data_o   (stage_data),
        .sticky_o (stage_sticky)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            sticky_q <= 1'b0;
            shift_q  <= '0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
            shift_q  <= shift_d;
            fill_q   <= fill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        sticky_d = sticky_q;
        shift_d  = shift_q;
        fill_d   = fill_q;
        accept   = InValid && in_ready;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    data_d   = A;
                    shift_d  = Shift;
                    fill_d   = A[WIDTH-1] & Arith;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else if (state_q == DONE && OutReady) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    data_d   = stage_data;
                    sticky_d = sticky_q | stage_sticky;
                    cnt_d    = cnt_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result consumption frees the aligner in the same cycle.
    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == DONE && OutReady);
        out_valid = (state_q == DONE);
    end

    assign InReady   = in_ready;
    assign OutValid  = out_valid;
    assign Z         = data_q;
    assign Sticky    = sticky_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_align_shift_iter.sv
// Self-checking bench for align_shift_iter at WIDTH=8: directed cases plus a random scoreboard run.
module tb_align_shift_iter;
    import shift_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         InValid;
    logic         InReady;
    logic [7:0]   A;
    logic [2:0]   Shift;
    logic         Arith;
    logic         OutValid;
    logic         OutReady;
    logic [7:0]   Z;
    logic         Sticky;
    align_state_t dbg_state;

    logic [8:0]   exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           rnd_ready = 0;

    align_shift_iter #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .A         (A),
        .Shift     (Shift),
        .Arith     (Arith),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Z         (Z),
        .Sticky    (Sticky),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [2:0] sh, input logic ar);
        logic [7:0]        ones;
        logic [7:0]        z;
        logic signed [7:0] sa;
        ones = 8'hFF;
        sa   = a;
        if (ar) z = sa >>> sh;
        else    z = a >> sh;
        return {z, |(a & ~(ones << sh))};
    endfunction

    always @(posedge clk) begin
        #1;
        if (rnd_ready) OutReady = 1'($urandom_range(0, 1));
    end

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("out_z", 32'(Z), 32'(e[8:1]));
                check("out_sticky", 32'(Sticky), 32'(e[0]));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [2:0] sh, input logic ar, input logic [8:0] e);
        bit done;
        done    = 0;
        InValid = 1'b1;
        A       = a;
        Shift   = sh;
        Arith   = ar;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (InReady) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
        InValid = 1'b0;
    endtask

    task automatic wait_out();
        bit seen;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (OutValid) seen = 1;
        end
        if (!seen) check("wait_out_timeout", 32'(seen), 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] zr;
        logic       sr;
        int         k;

        reset_n  = 1'b0;
        InValid  = 1'b0;
        A        = '0;
        Shift    = '0;
        Arith    = 1'b0;
        OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(InReady), 32'd1);
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_z", 32'(Z), 32'd0);
        check("rst_sticky", 32'(Sticky), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;

        // Directed results with hand-derived expectations.
        send(8'b1011_0110, 3'd3, 1'b0, {8'b0001_0110, 1'b1});
        send(8'b1011_0110, 3'd3, 1'b1, {8'b1111_0110, 1'b1});
        send(8'h80, 3'd7, 1'b0, {8'h01, 1'b0});
        send(8'h0F, 3'd4, 1'b0, {8'h00, 1'b1});
        send(8'h81, 3'd7, 1'b1, {8'hFF, 1'b1});
        drain();

        // Shift=0 passes A through with fixed latency.
        @(posedge clk);
        #1;
        send(8'hA5, 3'd0, 1'b0, {8'hA5, 1'b0});
        k = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_in_ready", 32'(InReady), 32'd0);
            if (OutValid) break;
        end
        check("latency", 32'(k), 32'd4);
        drain();

        // Backpressure: result held, no accept until consumption.
        @(posedge clk);
        #1;
        OutReady = 1'b0;
        send(8'h3D, 3'd2, 1'b0, {8'h0F, 1'b1});
        wait_out();
        zr = Z;
        sr = Sticky;
        @(posedge clk);
        #1;
        InValid = 1'b1;
        A       = 8'hC3;
        Shift   = 3'd1;
        Arith   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("hold_z", 32'(Z), 32'(zr));
            check("hold_sticky", 32'(Sticky), 32'(sr));
            check("hold_in_ready", 32'(InReady), 32'd0);
            check("hold_out_valid", 32'(OutValid), 32'd1);
            @(posedge clk);
            #1;
        end
        OutReady = 1'b1;
        @(negedge clk);
        check("same_cycle_accept", 32'(InReady), 32'd1);
        exp_q.push_back({8'hE1, 1'b1});
        @(posedge clk);
        #1;
        InValid = 1'b0;
        drain();

        // Reset in mid-operation discards the operand.
        @(posedge clk);
        #1;
        InValid = 1'b1;
        A       = 8'hFF;
        Shift   = 3'd5;
        Arith   = 1'b0;
        @(posedge clk);
        #1;
        InValid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_state", 32'(dbg_state), 32'(SHIFT));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(OutValid), 32'd0);
        check("mid_rst_z", 32'(Z), 32'd0);
        check("mid_rst_sticky", 32'(Sticky), 32'd0);
        check("mid_rst_in_ready", 32'(InReady), 32'd1);
        repeat (10) @(posedge clk);
        #1;

        // Random operands with random consumer backpressure.
        rnd_ready = 1;
        for (int n = 0; n < 10000; n++) begin
            logic [7:0] ra;
            logic [2:0] rs;
            logic       rr;
            ra = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            rr = 1'($urandom_range(0, 1));
            send(ra, rs, rr, model(ra, rs, rr));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_ready = 0;
        @(posedge clk);
        #2;
        OutReady = 1'b1;
        drain();
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
